// File: rtl/tanh_share_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// tanh_sched_pkg
//   Shared constants and helpers for the tanh sharing scheduler.
//   - DATA_W        : default operand/result width (float32)
//   - FP_ZERO/FP_ONE: float32 bit patterns used as reset/reference values
//   - id_w(n)       : width of a requester index for n requesters
// ----------------------------------------------------------------------------
package tanh_sched_pkg;

    localparam int          DATA_W  = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    // Never returns 0, so a requester index always has at least one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tanh_share_scheduler_if.sv
// ----------------------------------------------------------------------------
// tanh_share_scheduler_if
//   Requester-side and response-side bus of the tanh sharing scheduler.
//   - req_valid/req_data/req_ready : per-requester operand handshake
//   - resp_valid/resp_id/resp_data : tagged result stream (no backpressure)
//   - busy                         : any operand still in flight
//   Modports:
//     master : the requesters/consumer (drive requests, observe results)
//     slave  : the scheduler
// ----------------------------------------------------------------------------
interface tanh_share_scheduler_if
    import tanh_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = tanh_sched_pkg::DATA_W,
    parameter int ID_W    = id_w(NUM_REQ)
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      resp_valid;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W-1:0]         resp_data;
    logic                      busy;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_data,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_data,
        output busy
    );

endinterface

// File: rtl/tanh_share_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at the
//   requester after ptr (wrapping modulo NUM_REQ); the first asserted request
//   wins.
//   Ports:
//     req     : request vector
//     ptr     : index of the most recently granted requester
//     gnt     : one-hot grant, all-zero when no request is asserted
//     gnt_idx : index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter
    import tanh_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic found;
    int   cand;

    // Walk offsets 1..NUM_REQ so ptr itself is considered last; that is what
    // gives a continuously valid requester a bound of NUM_REQ-1 grants.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/tanh_share_scheduler.sv
// ----------------------------------------------------------------------------
// tanh_share_scheduler
//   Shares one pipelined tanh unit between NUM_REQ requesters. One operand is
//   accepted per cycle by round-robin arbitration, registered into tanh_in,
//   and its requester ID travels down a shift pipe matched to the unit
//   latency so that the result leaving the unit can be tagged.
//   Ports:
//     clk      : rising-edge clock shared with the tanh unit
//     rst_n    : asynchronous active-low reset
//     bus      : requester handshake and tagged response (slave modport)
//     tanh_in  : registered operand towards the tanh unit
//     tanh_out : result from the tanh unit (passed straight to resp_data)
// ----------------------------------------------------------------------------
module tanh_share_scheduler
    import tanh_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = tanh_sched_pkg::DATA_W,
    parameter int TANH_LATENCY = 1,
    parameter int ID_W         = id_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tanh_share_scheduler_if.slave bus,
    output logic [DATA_W-1:0]    tanh_in,
    input  logic [DATA_W-1:0]    tanh_out
);

    // One stage for the tanh_in register plus TANH_LATENCY stages inside the
    // unit, so the last stage lines up with tanh_out.
    localparam int DEPTH = TANH_LATENCY + 1;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               accept;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  tanh_in_q, tanh_in_d;
    logic [DEPTH-1:0]   vpipe_q, vpipe_d;
    logic [ID_W-1:0]    idpipe_q [DEPTH];
    logic [ID_W-1:0]    idpipe_d [DEPTH];

    logic [DATA_W-1:0]  req_data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The arbiter only grants a valid requester, so any grant is an accept.
    // There is no downstream backpressure to qualify it with.
    assign accept = |gnt;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        tanh_in_d   = tanh_in_q;
        vpipe_d     = {vpipe_q[DEPTH-2:0], accept};
        idpipe_d[0] = gnt_idx;
        for (int s = 1; s < DEPTH; s++) begin
            idpipe_d[s] = idpipe_q[s-1];
        end
        if (accept) begin
            rr_ptr_d  = gnt_idx;
            tanh_in_d = req_data_arr[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= ID_W'(NUM_REQ - 1);
            tanh_in_q <= FP_ZERO[DATA_W-1:0];
            vpipe_q   <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                idpipe_q[s] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            tanh_in_q <= tanh_in_d;
            vpipe_q   <= vpipe_d;
            for (int s = 0; s < DEPTH; s++) begin
                idpipe_q[s] <= idpipe_d[s];
            end
        end
    end

    // Grants are masked by rst_n so they drop the instant reset asserts,
    // not at the next edge.
    assign bus.req_ready  = gnt & {NUM_REQ{rst_n}};
    assign bus.resp_valid = vpipe_q[DEPTH-1];
    assign bus.resp_id    = idpipe_q[DEPTH-1];
    assign bus.resp_data  = tanh_out;
    assign bus.busy       = |vpipe_q;
    assign tanh_in        = tanh_in_q;

endmodule

// File: doc/tanh_share_scheduler.md
Name: tanh_share_scheduler

Overview:
Round-robin scheduler that shares one pipelined `tanh` activation unit (32-bit IEEE-754 single precision) between NUM_REQ requesters, such as parallel convolution/pooling lanes.
- Accepts at most one operand per cycle through per-requester valid/ready handshakes.
- Drives the operand into the `tanh` unit.
- Tracks each in-flight operand's requester ID through a shift pipeline matched to the unit latency.
- Returns each result tagged with that ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 32, operand/result width (float32).
- TANH_LATENCY, 1, clock edges from the `tanh` unit sampling input_data to output_data being valid (≥1).
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk, input, 1, rising-edge clock shared with the `tanh` unit.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester operand valid.
- req_data, input, NUM_REQ*DATA_W, packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready, output, NUM_REQ, per-requester grant; one-hot or zero.
- tanh_in, output, DATA_W, registered operand; wired to `tanh` input_data.
- tanh_out, input, DATA_W, from `tanh` output_data.
- resp_valid, output, 1, result valid for exactly one cycle per accepted operand.
- resp_id, output, ID_W, requester that issued the result.
- resp_data, output, DATA_W, tanh result; equals tanh_out while resp_valid=1.
- busy, output, 1, high while any operand is in flight.

Behaviour:
- Reset (async, rst_n=0):
  - tanh_in=0, valid pipe and ID pipe = 0, rr_ptr=NUM_REQ-1.
  - resp_valid=0, resp_id=0, busy=0, req_ready=0.
  - Takes effect immediately, without waiting for a clock edge.
- Arbitration (combinational from req_valid and rr_ptr):
  - Search requesters starting at rr_ptr+1 mod NUM_REQ; the first with req_valid=1 gets req_ready=1.
  - req_ready=0 for all requesters during reset and when no requester is valid.
  - No backpressure exists, so a grant is issued every cycle any request is valid: 100% unit utilisation.
- Accept:
  - Acceptance = req_valid[i] & req_ready[i] at a rising edge E0.
  - At E0: tanh_in<=req_data[i], vpipe[0]<=1, idpipe[0]<=i, rr_ptr<=i.
  - With no accept: vpipe[0]<=0; tanh_in and rr_ptr hold.
- Pipeline:
  - vpipe/idpipe are TANH_LATENCY+1 stages deep and shift every cycle.
  - resp_valid = vpipe[last], resp_id = idpipe[last], resp_data = tanh_out (pass-through).
  - Latency: an operand accepted at edge E0 produces resp_valid high in the cycle after edge E0+TANH_LATENCY.
  - Results return strictly in acceptance order.
- busy = OR of all vpipe stages.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Boundary conditions:
  - All requesters valid: grants rotate 0,1,2,3,0,…
  - Single requester valid: it is granted every cycle.
  - A requester dropping req_valid in the same cycle rr_ptr passes it: it is skipped and the pointer does not stall.
  - Reset mid-operation: in-flight results are discarded and no resp_valid follows. The `tanh` unit has no reset; its output is ignored because vpipe is cleared.
  - Consumer side must accept resp_valid in every cycle it is asserted; no result buffering exists.
- Arithmetic: none in this block; data is routed bit-exact.

Decomposition:
- Package tanh_sched_pkg holds:
  - DATA_W=32 and float32 constants FP_ZERO=32'h00000000 and FP_ONE=32'h3F800000.
  - The id_w(n) function.
- Sub-module rr_arbiter (NUM_REQ): inputs req and ptr; outputs one-hot gnt and gnt_idx; purely combinational.
- The top holds the pointer, the operand register, and the valid/ID shift pipes.

Test Plan:
- Bench uses a stub `tanh` model with configurable TANH_LATENCY that returns input XOR 32'h80000000, so data routing is checkable bit-exact.
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then high with all req_valid=0.
  - Required: req_ready=0, resp_valid=0, busy=0, tanh_in=0.
- Single request:
  - Stimulus: requester 2 sends 32'h3F000000 with TANH_LATENCY=1.
  - Required: resp_valid exactly 2 cycles after acceptance, resp_id=2, resp_data=32'hBF000000, busy low the cycle after.
- Full contention:
  - Stimulus: all 4 requesters continuously valid with data 32'h3E4CCCCD+i, for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; resp_id follows the same order, one result per cycle.
- Sparse plus skip:
  - Stimulus: only requesters 1 and 3 valid.
  - Required: alternating grants 1,3,1,3; requesters 0 and 2 never receive req_ready.
- Latency sweep:
  - Stimulus: repeat the contention test with TANH_LATENCY=3 and TANH_LATENCY=5.
  - Required: resp_valid delayed to TANH_LATENCY+1 cycles after acceptance; data/ID pairing intact.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 with 3 operands in flight.
  - Required: resp_valid=0 immediately and no late responses; after release, rr_ptr restarts so requester 0 wins first.
